// File: rtl/debounce_pkg.sv
// debounce_pkg: parameter limits and counter sizing shared by the debounce logic.
package debounce_pkg;
    localparam int CHANNELS_MIN = 1;
    localparam int CHANNELS_MAX = 32;
    localparam int STABLE_MIN   = 1;
    localparam int STABLE_MAX   = 65535;
    localparam int SYNC_MIN     = 2;
    localparam int SYNC_MAX     = 4;

    function automatic int cnt_width(input int stable_cnt);
        return $clog2(stable_cnt + 1);
    endfunction
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one input's synchroniser, stability counter and edge pulses.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int STABLE_CNT  = 7,
    parameter int SYNC_STAGES = 2,
    parameter bit INIT_LEVEL  = 1'b0
) (
    input  logic clk,
    input  logic clear_n,
    input  logic tick,
    input  logic raw_in,
    output logic out,
    output logic rise,
    output logic fall
);
    localparam int CW = cnt_width(STABLE_CNT);
    localparam logic [CW-1:0] LAST = CW'(STABLE_CNT - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic out_q, out_d, rise_q, rise_d, fall_q, fall_d;
    logic sync, agree, load;

    assign sync   = sync_q[SYNC_STAGES-1];
    assign agree  = sync == out_q;
    assign load   = tick && !agree && cnt_q == LAST;
    assign sync_d = {sync_q[SYNC_STAGES-2:0], raw_in};
    // a single agreeing sample abandons any pending change
    assign cnt_d  = !tick ? cnt_q : (agree || load) ? '0 : cnt_q + CW'(1);
    assign out_d  = load ? sync : out_q;
    assign rise_d = load && sync;
    assign fall_d = load && !sync;

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            sync_q <= {SYNC_STAGES{INIT_LEVEL}};
            cnt_q  <= '0;
            out_q  <= INIT_LEVEL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign out  = out_q;
    assign rise = rise_q;
    assign fall = fall_q;
endmodule

// File: rtl/debounce_bank.sv
// debounce_bank: CHANNELS independent debouncers with a shared change flag.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int STABLE_CNT  = 7,
    parameter int SYNC_STAGES = 2,
    parameter bit INIT_LEVEL  = 1'b0
) (
    input  logic                clk,
    input  logic                clear_n,
    input  logic                tick,
    input  logic [CHANNELS-1:0] raw_in,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic                any_change
);
    if (CHANNELS < CHANNELS_MIN || CHANNELS > CHANNELS_MAX ||
        STABLE_CNT < STABLE_MIN || STABLE_CNT > STABLE_MAX ||
        SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_params
        $error("debounce_bank: illegal parameters CHANNELS=%0d STABLE_CNT=%0d SYNC_STAGES=%0d",
               CHANNELS, STABLE_CNT, SYNC_STAGES);
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        debounce_channel #(
            .STABLE_CNT (STABLE_CNT),
            .SYNC_STAGES(SYNC_STAGES),
            .INIT_LEVEL (INIT_LEVEL)
        ) u_ch (
            .clk    (clk),
            .clear_n(clear_n),
            .tick   (tick),
            .raw_in (raw_in[g]),
            .out    (out[g]),
            .rise   (rise[g]),
            .fall   (fall[g])
        );
    end

    assign any_change = |(rise | fall);
endmodule
